branch_cmp_unit: RTL and testbench
==================================

BRANCH_CMP_UNIT -- requirements
Module: branch_cmp_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, minimum 2.
REQ-002 SHALL have parameter DEPTH, default 16: number of BHT entries, a power of 2, minimum 2. IW = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a branch request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-007 SHALL have ports cmp_a and cmp_b, input, WIDTH bits each: the operands.
REQ-008 SHALL have port cmp_op, input, 3 bits: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved.
REQ-009 SHALL have port pc, input, 32 bits: branch address; BHT index is pc[IW+1:2].
REQ-010 SHALL have port flush, input, 1 bit: discard the in-flight result.
REQ-011 SHALL have port res_valid, output, 1 bit: a result is held.
REQ-012 SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have ports res_taken, res_pred and res_mispredict, output, 1 bit each: actual outcome, predicted outcome, and actual != predicted.
REQ-014 SHALL have port miss_cnt, output, 16 bits: saturating count of mispredicts.

Function
REQ-015 Accept SHALL occur when req_valid && req_ready; req_ready = !flush && (!res_valid || res_ready).
REQ-016 On accept, the unit SHALL register operands, op, index and the BHT prediction; res_valid SHALL be 1 from the next cycle (latency 1).
REQ-017 Result outputs SHALL hold stable while res_valid && !res_ready.
REQ-018 beq SHALL mean a==b; bne SHALL mean a!=b.
REQ-019 blez, bgtz, bltz and bgez SHALL compare cmp_a, signed, against 0. For example, blez is true when a==0 or a[WIDTH-1]==1. These four ops SHALL ignore cmp_b.
REQ-020 Ops 0 and 7 SHALL give res_taken=0 and res_pred=0, and SHALL cause no BHT update.
REQ-021 Each BHT entry SHALL be a 2-bit saturating counter; prediction = counter[1].
REQ-022 On a result handshake (res_valid && res_ready && !flush) for a real op, the entry SHALL increment if taken (saturate at 3) or decrement if not taken (saturate at 0).
REQ-023 If an accept in the same cycle indexes the entry being updated, the prediction SHALL use the post-update value.
REQ-024 On a result handshake with res_mispredict=1, miss_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 flush SHALL clear res_valid next cycle, with no BHT update and no miss_cnt change; no accept SHALL occur during flush.
REQ-026 Back-to-back accepts SHALL sustain 1 per cycle when res_ready is held at 1.

Reset
REQ-027 When reset=0, the unit SHALL asynchronously set res_valid=0, res_taken=0, res_pred=0, res_mispredict=0 and miss_cnt=0, and all BHT entries to 2'b01.
REQ-028 req_ready SHALL be 0 while in reset.
REQ-029 Reset mid-operation SHALL drop the held result with no update.
REQ-030 The first accept SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-031 With macro BRANCH_CMP_BHT_EN defined, the BHT SHALL be built per REQ-021..023.
REQ-032 With BRANCH_CMP_BHT_EN undefined, there SHALL be no BHT storage; res_pred SHALL be 0 and res_mispredict SHALL equal res_taken. miss_cnt still counts.

Verification
REQ-033 Scenario: reset; beq a=5, b=5, pc=0x3000, res_ready=1. Required: next cycle res_taken=1, res_pred=0, res_mispredict=1, miss_cnt=1.
REQ-034 Scenario: same pc, four taken beq back-to-back. Required: predictions 0,1,1,1 (counter 01→10→11→11 saturates); miss_cnt=1 after the first result.
REQ-035 Scenario: blez with a=0, a=0x80000000 and a=1. Required: taken 1, 1, 0. Scenario: bgtz with a=0x7FFFFFFF. Required: taken 1.
REQ-036 Scenario: result held with res_ready=0 for 3 cycles, new req_valid=1. Required: req_ready=0 and outputs stable; accept occurs in the cycle res_ready=1.
REQ-037 Scenario: flush=1 while res_valid=1 and a request is pending. Required: no accept, res_valid=0 next cycle, BHT entry and miss_cnt unchanged.
REQ-038 Scenario: build without BRANCH_CMP_BHT_EN, then bne a=1, b=2. Required: res_pred=0, res_mispredict=1.

Source files
------------

// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit
//   Branch condition evaluator with an optional branch history table (BHT)
//   of 2-bit saturating counters and a saturating mispredict counter.
//   A request is accepted on req_valid && req_ready, and its result is
//   presented one cycle later. The result is held until res_ready is seen.
//
// Build option:
//   BRANCH_CMP_BHT_EN  - when defined, a DEPTH-entry BHT indexed by
//                        pc[IW+1:2] supplies the prediction. When undefined,
//                        no BHT is built and the prediction is always 0.
//
// Parameters:
//   WIDTH  operand width (>= 2)
//   DEPTH  BHT entries (power of 2, >= 2)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   cmp_a, cmp_b   operands
//   cmp_op         0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved
//   pc             branch address (BHT index source)
//   flush          discards the held result and blocks accepts this cycle
//   res_valid/res_ready   result handshake
//   res_taken      actual outcome
//   res_pred       predicted outcome
//   res_mispredict res_taken != res_pred
//   miss_cnt       saturating count of mispredicted result handshakes
module branch_cmp_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] cmp_a,
    input  logic [WIDTH-1:0] cmp_b,
    input  logic [2:0]       cmp_op,
    input  logic [31:0]      pc,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic             res_pred,
    output logic             res_mispredict,
    output logic [15:0]      miss_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLEZ = 3'd3,
        OP_BGTZ = 3'd4,
        OP_BLTZ = 3'd5,
        OP_BGEZ = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_e              r_op;
    logic             res_valid_q;
    logic [15:0]      miss_q;
    logic             accept;
    logic             handshake;
    logic             taken;
    logic             a_zero;
    logic             a_neg;
    logic             unused_pc;

    // Only part of pc feeds the index (and none of it without the BHT).
    assign unused_pc = ^pc;

    assign req_ready = reset && !flush && (!res_valid_q || res_ready);
    assign accept    = req_valid && req_ready;
    assign handshake = res_valid_q && res_ready && !flush;

    // Outcome is evaluated from the registered operands so it stays stable
    // for as long as the result is held.
    assign a_zero = (r_a == '0);
    assign a_neg  = r_a[WIDTH-1];

    always_comb begin
        taken = 1'b0;
        case (r_op)
            OP_BEQ:  taken = (r_a == r_b);
            OP_BNE:  taken = (r_a != r_b);
            OP_BLEZ: taken = a_zero || a_neg;
            OP_BGTZ: taken = !a_zero && !a_neg;
            OP_BLTZ: taken = a_neg;
            OP_BGEZ: taken = !a_neg;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_NONE;
        end else if (flush) begin
            res_valid_q <= 1'b0;
        end else if (accept) begin
            res_valid_q <= 1'b1;
            r_a         <= cmp_a;
            r_b         <= cmp_b;
            r_op        <= op_e'(cmp_op);
        end else if (handshake) begin
            res_valid_q <= 1'b0;
        end
    end

`ifdef BRANCH_CMP_BHT_EN
    logic [1:0]    bht [DEPTH];
    logic [IW-1:0] r_idx;
    logic [IW-1:0] req_idx;
    logic          r_pred;
    logic          real_op_q;
    logic          real_op_req;
    logic          upd_en;
    logic [1:0]    upd_ctr;
    logic          pred_now;

    assign req_idx     = pc[IW+1:2];
    assign real_op_q   = (r_op != OP_NONE) && (r_op != OP_RSVD);
    assign real_op_req = (cmp_op != 3'd0) && (cmp_op != 3'd7);
    assign upd_en      = handshake && real_op_q;

    always_comb begin
        upd_ctr = bht[r_idx];
        if (taken) begin
            if (bht[r_idx] != 2'd3) upd_ctr = bht[r_idx] + 2'd1;
        end else begin
            if (bht[r_idx] != 2'd0) upd_ctr = bht[r_idx] - 2'd1;
        end
    end

    // A same-cycle update to the entry being read is forwarded so the new
    // request sees the post-update counter.
    always_comb begin
        pred_now = 1'b0;
        if (real_op_req) begin
            if (upd_en && (r_idx == req_idx)) pred_now = upd_ctr[1];
            else                              pred_now = bht[req_idx][1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
        end else if (upd_en) begin
            bht[r_idx] <= upd_ctr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_pred <= 1'b0;
        end else if (accept) begin
            r_idx  <= req_idx;
            r_pred <= pred_now;
        end
    end

    assign res_pred = r_pred;
`else
    assign res_pred = 1'b0;
`endif

    assign res_taken      = taken;
    assign res_mispredict = taken ^ res_pred;
    assign res_valid      = res_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_q <= '0;
        end else if (handshake && res_mispredict && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
        end
    end

    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed, table-driven bench for branch_cmp_unit. Expectations follow the
// build: with BRANCH_CMP_BHT_EN a small counter model supplies predictions,
// otherwise predictions are 0.
module tb_branch_cmp_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  cmp_op;
    logic [31:0] pc;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic        res_pred;
    logic        res_mispredict;
    logic [15:0] miss_cnt;

    branch_cmp_unit #(.WIDTH(32), .DEPTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .cmp_a          (cmp_a),
        .cmp_b          (cmp_b),
        .cmp_op         (cmp_op),
        .pc             (pc),
        .flush          (flush),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_taken      (res_taken),
        .res_pred       (res_pred),
        .res_mispredict (res_mispredict),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        taken;
    } vec_t;

    vec_t       vecs [15];
    int         n_cmp;
    int         n_bad;
    logic [1:0] mb [16];
    int         exp_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mb[i] = 2'b01;
        exp_miss = 0;
    endtask

    function automatic logic mpred(input logic [2:0] op, input logic [31:0] p);
        logic r;
        r = 1'b0;
`ifdef BRANCH_CMP_BHT_EN
        r = mb[p[5:2]][1];
`endif
        if (op == 3'd0 || op == 3'd7) r = 1'b0;
        return r;
    endfunction

    // Apply the effect of one completed result handshake to the model.
    task automatic mupd(input logic [2:0] op, input logic [31:0] p, input logic tk, input logic pr);
        logic [3:0] ix;
        ix = p[5:2];
        if (op != 3'd0 && op != 3'd7) begin
            if (tk && mb[ix] != 2'd3) mb[ix] = mb[ix] + 2'd1;
            else if (!tk && mb[ix] != 2'd0) mb[ix] = mb[ix] - 2'd1;
        end
        if ((tk != pr) && exp_miss < 65535) exp_miss++;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        cmp_op = op;
        cmp_a  = a;
        cmp_b  = b;
        pc     = p;
    endtask

    logic ep;
    logic ep2;
    logic hp [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        flush     = 1'b0;
        set_req(3'd0, 32'd0, 32'd0, 32'd0);

        vecs[0]  = '{3'd1, 32'd5,          32'd5, 32'h3000, 1'b1};
        vecs[1]  = '{3'd1, 32'd5,          32'd6, 32'h3004, 1'b0};
        vecs[2]  = '{3'd2, 32'd1,          32'd2, 32'h3008, 1'b1};
        vecs[3]  = '{3'd2, 32'd7,          32'd7, 32'h300C, 1'b0};
        vecs[4]  = '{3'd3, 32'd0,          32'd9, 32'h3010, 1'b1};
        vecs[5]  = '{3'd3, 32'h8000_0000,  32'd0, 32'h3014, 1'b1};
        vecs[6]  = '{3'd3, 32'd1,          32'd0, 32'h3018, 1'b0};
        vecs[7]  = '{3'd4, 32'h7FFF_FFFF,  32'd0, 32'h301C, 1'b1};
        vecs[8]  = '{3'd4, 32'd0,          32'd5, 32'h3000, 1'b0};
        vecs[9]  = '{3'd5, 32'hFFFF_FFFF,  32'd0, 32'h3004, 1'b1};
        vecs[10] = '{3'd5, 32'd0,          32'hF, 32'h3008, 1'b0};
        vecs[11] = '{3'd6, 32'd0,          32'd0, 32'h300C, 1'b1};
        vecs[12] = '{3'd6, 32'h8000_0000,  32'd0, 32'h3010, 1'b0};
        vecs[13] = '{3'd0, 32'd5,          32'd5, 32'h3014, 1'b0};
        vecs[14] = '{3'd7, 32'd3,          32'd3, 32'h3018, 1'b0};

`ifdef BRANCH_CMP_BHT_EN
        hp = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
        hp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset state
        tick();
        tick();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_taken", {31'd0, res_taken}, 32'd0);
        chk("rst_pred", {31'd0, res_pred}, 32'd0);
        chk("rst_mispredict", {31'd0, res_mispredict}, 32'd0);
        chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        reset = 1'b1;

        // Table vectors, one request at a time with res_ready high
        res_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            set_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p);
            req_valid = 1'b1;
            #1;
            chk("vec_req_ready", {31'd0, req_ready}, 32'd1);
            ep = mpred(vecs[i].op, vecs[i].p);
            tick();
            req_valid = 1'b0;
            chk("vec_res_valid", {31'd0, res_valid}, 32'd1);
            chk("vec_taken", {31'd0, res_taken}, {31'd0, vecs[i].taken});
            chk("vec_pred", {31'd0, res_pred}, {31'd0, ep});
            chk("vec_mispredict", {31'd0, res_mispredict}, {31'd0, vecs[i].taken ^ ep});
            mupd(vecs[i].op, vecs[i].p, vecs[i].taken, ep);
            tick();
            chk("vec_res_drained", {31'd0, res_valid}, 32'd0);
            chk("vec_miss_cnt", {16'd0, miss_cnt}, exp_miss);
        end

        // Four taken beq back-to-back on a fresh entry
        set_req(3'd1, 32'd9, 32'd9, 32'h3020);
        req_valid = 1'b1;
        #1;
        chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                tick();
                req_valid = 1'b0;
            end else begin
                tick();
            end
            chk("b2b_res_valid", {31'd0, res_valid}, 32'd1);
            chk("b2b_taken", {31'd0, res_taken}, 32'd1);
            chk("b2b_pred", {31'd0, res_pred}, {31'd0, hp[k]});
            if (k > 0) chk("b2b_miss_cnt", {16'd0, miss_cnt}, exp_miss);
            if (k < 3) begin
                #1;
                chk("b2b_ready_sustain", {31'd0, req_ready}, 32'd1);
            end
            mupd(3'd1, 32'h3020, 1'b1, hp[k]);
        end
        tick();
        chk("b2b_drained", {31'd0, res_valid}, 32'd0);
        chk("b2b_miss_final", {16'd0, miss_cnt}, exp_miss);

        // Back-pressure: result held for three cycles with a request waiting
        res_ready = 1'b0;
        set_req(3'd2, 32'd3, 32'd4, 32'h3044);
        req_valid = 1'b1;
        ep = mpred(3'd2, 32'h3044);
        tick();
        set_req(3'd1, 32'd8, 32'd8, 32'h3048);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_taken", {31'd0, res_taken}, 32'd1);
            chk("stall_pred", {31'd0, res_pred}, {31'd0, ep});
            chk("stall_mispredict", {31'd0, res_mispredict}, {31'd0, 1'b1 ^ ep});
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("stall_release_ready", {31'd0, req_ready}, 32'd1);
        mupd(3'd2, 32'h3044, 1'b1, ep);
        ep2 = mpred(3'd1, 32'h3048);
        tick();
        req_valid = 1'b0;
        chk("stall_next_valid", {31'd0, res_valid}, 32'd1);
        chk("stall_next_taken", {31'd0, res_taken}, 32'd1);
        chk("stall_next_pred", {31'd0, res_pred}, {31'd0, ep2});
        chk("stall_miss_cnt", {16'd0, miss_cnt}, exp_miss);
        mupd(3'd1, 32'h3048, 1'b1, ep2);
        tick();
        chk("stall_miss_final", {16'd0, miss_cnt}, exp_miss);

        // Flush while a result is held and a request is pending
        res_ready = 1'b0;
        set_req(3'd1, 32'd1, 32'd1, 32'h3030);
        req_valid = 1'b1;
        tick();
        chk("flush_pre_valid", {31'd0, res_valid}, 32'd1);
        set_req(3'd2, 32'd1, 32'd2, 32'h3034);
        flush     = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_res_valid", {31'd0, res_valid}, 32'd0);
        chk("flush_miss_cnt", {16'd0, miss_cnt}, exp_miss);
        // Probe the same entry: an update from the flushed result would show here
        set_req(3'd1, 32'd1, 32'd1, 32'h3030);
        req_valid = 1'b1;
        ep = mpred(3'd1, 32'h3030);
        tick();
        req_valid = 1'b0;
        chk("flush_probe_taken", {31'd0, res_taken}, 32'd1);
        chk("flush_probe_pred", {31'd0, res_pred}, {31'd0, ep});
        mupd(3'd1, 32'h3030, 1'b1, ep);
        tick();
        chk("flush_probe_miss", {16'd0, miss_cnt}, exp_miss);

        // Reset while a result is held, then accept right after release
        res_ready = 1'b0;
        set_req(3'd2, 32'd1, 32'd2, 32'h3000);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mid_rst_pre_valid", {31'd0, res_valid}, 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_taken", {31'd0, res_taken}, 32'd0);
        chk("mid_rst_mispredict", {31'd0, res_mispredict}, 32'd0);
        chk("mid_rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        tick();
        reset     = 1'b1;
        res_ready = 1'b1;
        set_req(3'd1, 32'd4, 32'd4, 32'h3000);
        req_valid = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        ep = mpred(3'd1, 32'h3000);
        tick();
        req_valid = 1'b0;
        chk("post_rst_valid", {31'd0, res_valid}, 32'd1);
        chk("post_rst_taken", {31'd0, res_taken}, 32'd1);
        chk("post_rst_pred", {31'd0, res_pred}, {31'd0, ep});
        mupd(3'd1, 32'h3000, 1'b1, ep);
        tick();
        chk("post_rst_miss_cnt", {16'd0, miss_cnt}, exp_miss);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
